// File: rtl/wave_player_if.sv
// wave_player_if: controller handshake, waveform-memory read port and sample stream of wave_player
//   start/busy/addr_i/wait_i/ctrl_i/qsel_i : entry request from the queue controller
//   mem_en/mem_addr/mem_dout                : waveform memory read port (2-cycle read latency)
//   m_axis_tdata/m_axis_tvalid/gate_o/qsel_o: sample stream toward the DAC datapath
interface wave_player_if #(
    parameter int N = 12,
    parameter int B = 32
);
    logic         start;
    logic         busy;
    logic [31:0]  addr_i;
    logic [31:0]  wait_i;
    logic [7:0]   ctrl_i;
    logic [7:0]   qsel_i;
    logic         mem_en;
    logic [N-1:0] mem_addr;
    logic [B-1:0] mem_dout;
    logic [B-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         gate_o;
    logic [7:0]   qsel_o;
    modport slave (
        input  start, addr_i, wait_i, ctrl_i, qsel_i, mem_dout,
        output busy, mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, gate_o, qsel_o
    );
    modport master (
        output start, addr_i, wait_i, ctrl_i, qsel_i, mem_dout,
        input  busy, mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, gate_o, qsel_o
    );
endinterface

// File: rtl/wave_player.sv
// wave_player: plays one queue entry (delay, then L samples from base, one-shot or periodic) as a sample stream
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : wave_player_if.slave (controller handshake, memory read port, sample stream)
module wave_player #(
    parameter int N = 12,
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         rstn,
    wave_player_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DELAY, PLAY, DRAIN, LOOP} state_t;
    state_t       r_state;
    logic [N-1:0] r_base;
    logic [N-1:0] r_mem_addr;
    logic [15:0]  r_len;
    logic [15:0]  r_idx;
    logic [31:0]  r_cnt;
    logic         r_per;
    logic         r_oe;
    logic         r_busy;
    logic         r_mem_en;
    logic [1:0]   r_v;
    logic [1:0]   r_e;
    logic [B-1:0] r_tdata;
    logic         r_tvalid;
    logic         r_gate;
    logic [7:0]   r_qsel;
    logic         w_accept;
    logic         w_last;
    assign w_accept = bus.start && (r_state == IDLE || r_state == LOOP);
    assign w_last   = (r_idx == r_len - 16'd1);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_per      <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_en   <= 1'b0;
            r_v        <= '0;
            r_e        <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_gate     <= 1'b0;
            r_qsel     <= '0;
        end else begin
            r_tvalid <= 1'b1;
            // valid and output-enable travel with each read so in-flight samples keep their own entry's gating
            r_v      <= {r_v[0], r_mem_en};
            r_e      <= {r_e[0], r_mem_en & r_oe};
            r_gate   <= r_v[1];
            r_tdata  <= r_e[1] ? bus.mem_dout : '0;
            if (w_accept) begin
                r_base     <= bus.addr_i[N-1:0];
                r_mem_addr <= bus.addr_i[N-1:0];
                r_len      <= bus.addr_i[31:16];
                r_per      <= bus.ctrl_i[0];
                r_oe       <= bus.ctrl_i[1];
                r_qsel     <= bus.qsel_i;
                r_idx      <= '0;
                r_busy     <= 1'b1;
                r_mem_en   <= 1'b0;
                if (bus.wait_i != 32'd0) begin
                    r_state <= DELAY;
                    r_cnt   <= bus.wait_i - 32'd1;
                end else if (bus.addr_i[31:16] != 16'd0) begin
                    r_state  <= PLAY;
                    r_mem_en <= 1'b1;
                end else begin
                    r_state <= DRAIN;
                    r_cnt   <= 32'd2;
                end
            end else begin
                case (r_state)
                    DELAY: begin
                        if (r_cnt != 32'd0) begin
                            r_cnt <= r_cnt - 32'd1;
                        end else if (r_len != 16'd0) begin
                            r_state    <= PLAY;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= r_base;
                        end else begin
                            r_state <= DRAIN;
                            r_cnt   <= 32'd2;
                        end
                    end
                    PLAY, LOOP: begin
                        if (w_last) begin
                            r_idx      <= '0;
                            r_mem_addr <= r_base;
                            if (r_per) begin
                                r_state <= LOOP;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state  <= DRAIN;
                                r_mem_en <= 1'b0;
                                r_cnt    <= 32'd2;
                            end
                        end else begin
                            r_idx      <= r_idx + 16'd1;
                            r_mem_addr <= r_mem_addr + N'(1);
                        end
                    end
                    DRAIN: begin
                        if (r_cnt == 32'd0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign bus.busy          = r_busy;
    assign bus.mem_en        = r_mem_en;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.gate_o        = r_gate;
    assign bus.qsel_o        = r_qsel;
endmodule

// File: tb/tb_wave_player.sv
// tb_wave_player: directed bench for wave_player with a 2-cycle-latency memory holding mem[k]=k
module tb_wave_player;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] r_d1;
    wave_player_if #(.N(12), .B(32)) bus ();
    wave_player #(.N(12), .B(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        r_d1         <= {20'h0, bus.mem_addr};
        bus.mem_dout <= r_d1;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 0, 64'(bus.busy), 64'd0);
        chk({tag, "_mem_en"}, 0, 64'(bus.mem_en), 64'd0);
        chk({tag, "_mem_addr"}, 0, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_tdata"}, 0, 64'(bus.m_axis_tdata), 64'd0);
        chk({tag, "_tvalid"}, 0, 64'(bus.m_axis_tvalid), 64'd0);
        chk({tag, "_gate"}, 0, 64'(bus.gate_o), 64'd0);
        chk({tag, "_qsel"}, 0, 64'(bus.qsel_o), 64'd0);
    endtask
    task automatic drive(input logic [11:0] base, input logic [15:0] len, input logic [31:0] wt,
                         input logic [7:0] ctrl, input logic [7:0] qsel);
        bus.start  = 1'b1;
        bus.addr_i = {len, 4'h0, base};
        bus.wait_i = wt;
        bus.ctrl_i = ctrl;
        bus.qsel_i = qsel;
    endtask
    // one-shot entry issued in the current cycle (t); checks cycles t+1..t+n
    task automatic run_entry(input string tag, input logic [11:0] base, input logic [15:0] len,
                             input logic [31:0] wt, input logic [7:0] ctrl, input logic [7:0] qsel,
                             input int hold, input int n);
        int w;
        int l;
        int last_busy;
        logic ae;
        logic se;
        logic [11:0] ea;
        logic [11:0] sa;
        w = int'(wt);
        l = int'(len);
        last_busy = w + l + 3;
        drive(base, len, wt, ctrl, qsel);
        for (int k = 1; k <= n; k++) begin
            tick();
            bus.start = (k < hold);
            ae = (k >= w + 1) && (k <= w + l);
            se = (k >= w + 4) && (k <= w + l + 3);
            ea = base + 12'(k - w - 1);
            sa = base + 12'(k - w - 4);
            chk({tag, "_busy"}, k, 64'(bus.busy), 64'(k <= last_busy));
            chk({tag, "_mem_en"}, k, 64'(bus.mem_en), 64'(ae));
            if (ae) chk({tag, "_mem_addr"}, k, 64'(bus.mem_addr), 64'(ea));
            chk({tag, "_gate"}, k, 64'(bus.gate_o), 64'(se));
            chk({tag, "_tdata"}, k, 64'(bus.m_axis_tdata), (se && ctrl[1]) ? 64'(sa) : 64'd0);
            if (k == 1) chk({tag, "_qsel"}, k, 64'(bus.qsel_o), 64'(qsel));
        end
    endtask
    initial begin
        logic [11:0] pa;
        logic [31:0] exp_q [0:4];
        bus.start  = 1'b0;
        bus.addr_i = '0;
        bus.wait_i = '0;
        bus.ctrl_i = '0;
        bus.qsel_i = '0;
        #13;
        chk_zero("reset");
        #9 rstn = 1'b1;
        tick();
        chk("tvalid_rise", 0, 64'(bus.m_axis_tvalid), 64'd1);
        chk("idle_busy", 0, 64'(bus.busy), 64'd0);
        tick();
        run_entry("basic", 12'h010, 16'd4, 32'd0, 8'h02, 8'h0A, 2, 10);
        tick();
        run_entry("wait5", 12'h010, 16'd4, 32'd5, 8'h02, 8'h0B, 1, 14);
        tick();
        run_entry("gated", 12'h010, 16'd4, 32'd0, 8'h00, 8'h0C, 1, 10);
        tick();
        run_entry("wrap", 12'hFFE, 16'd4, 32'd0, 8'h02, 8'h0D, 1, 10);
        tick();
        run_entry("len0", 12'h123, 16'd0, 32'd3, 8'h02, 8'h0E, 7, 12);
        tick();
        drive(12'h020, 16'd3, 32'd0, 8'h03, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.start = 1'b0;
            pa = 12'h020 + 12'((k - 1) % 3);
            chk("per_mem_en", k, 64'(bus.mem_en), 64'd1);
            chk("per_mem_addr", k, 64'(bus.mem_addr), 64'(pa));
            chk("per_busy", k, 64'(bus.busy), 64'(k <= 3));
            if (k >= 4) chk("per_tdata", k, 64'(bus.m_axis_tdata), 64'(12'h020 + 12'((k - 4) % 3)));
        end
        drive(12'h100, 16'd2, 32'd0, 8'h02, 8'h05);
        exp_q[0] = 32'h022;
        exp_q[1] = 32'h020;
        exp_q[2] = 32'h021;
        exp_q[3] = 32'h100;
        exp_q[4] = 32'h101;
        for (int k = 9; k <= 14; k++) begin
            tick();
            bus.start = 1'b0;
            chk("new_busy", k, 64'(bus.busy), 64'(k <= 13));
            chk("new_mem_en", k, 64'(bus.mem_en), 64'(k <= 10));
            if (k <= 10) chk("new_mem_addr", k, 64'(bus.mem_addr), 64'(12'h100 + 12'(k - 9)));
            chk("new_gate", k, 64'(bus.gate_o), 64'(k <= 13));
            if (k <= 13) chk("new_tdata", k, 64'(bus.m_axis_tdata), 64'(exp_q[k - 9]));
            chk("new_qsel", k, 64'(bus.qsel_o), 64'h05);
        end
        tick();
        drive(12'h000, 16'd100, 32'd0, 8'h02, 8'h07);
        for (int k = 1; k <= 54; k++) begin
            tick();
            bus.start = 1'b0;
        end
        chk("mid_tdata", 54, 64'(bus.m_axis_tdata), 64'd50);
        chk("mid_gate", 54, 64'(bus.gate_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk_zero("midrst");
        #2 rstn = 1'b1;
        tick();
        chk("post_busy", 0, 64'(bus.busy), 64'd0);
        chk("post_mem_en", 0, 64'(bus.mem_en), 64'd0);
        chk("post_tvalid", 0, 64'(bus.m_axis_tvalid), 64'd1);
        run_entry("after_rst", 12'h040, 16'd2, 32'd1, 8'h02, 8'h09, 1, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
